load_burst_engine: RTL and testbench



---
 rtl/load_burst_engine.sv | 161 ++++++++++++++++
 tb/tb_load_burst_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_burst_engine.sv
// load_burst_engine: splits one DRAM->SRAM load command into AXI INCR read bursts, writing good beats to SRAM and retrying failed bursts.
module load_burst_engine #(
    parameter int DATA_W    = 32,
    parameter int DRAM_AW   = 12,
    parameter int SRAM_AW   = 8,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 8,
    parameter int MAX_BURST = 16,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_W   = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic [DRAM_AW-1:0] cmd_dram_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [2:0]         cmd_size,
    input  logic [SRAM_AW-1:0] cmd_sram_addr,
    input  logic [1:0]         cmd_sram_type,
    output logic [ID_W-1:0]    axi_arid,
    output logic [DRAM_AW-1:0] axi_araddr,
    output logic [7:0]         axi_arlen,
    output logic [2:0]         axi_arsize,
    output logic [1:0]         axi_arburst,
    output logic               axi_arvld,
    input  logic               axi_arrdy,
    input  logic [ID_W-1:0]    axi_rid,
    input  logic [DATA_W-1:0]  axi_rdata,
    input  logic [1:0]         axi_rresp,
    input  logic               axi_rlast,
    input  logic               axi_rvld,
    output logic               axi_rrdy,
    output logic               sram_vld,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_din,
    output logic [1:0]         sram_type,
    output logic               ld_done,
    output logic               ld_err,
    output logic               ld_busy,
    output logic [RETRY_W-1:0] retry_cnt
);
    typedef enum logic [2:0] {IDLE, AR, DATA, DONE, ERR} state_t;
    state_t state, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DRAM_AW-1:0] dram_q, dram_d;
    logic [SRAM_AW-1:0] sram_q, sram_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         type_q, type_d;
    logic [LEN_W-1:0]   rem_q, rem_d, rem_next;
    logic [7:0]         len_q, len_d;
    logic [8:0]         beat_q, beat_d, beats;
    logic               err_q, err_d, err_now, hit, good;
    logic [RETRY_W-1:0] retry_d;

    // arlen for the next burst: min(remaining, MAX_BURST) - 1
    function automatic logic [7:0] first_len(input logic [LEN_W-1:0] r);
        first_len = 8'((32'(r) > 32'(MAX_BURST)) ? 32'(MAX_BURST) - 32'd1 : 32'(r) - 32'd1);
    endfunction

    assign beats     = {1'b0, len_q} + 9'd1;
    assign rem_next  = rem_q - LEN_W'(beats);
    assign hit       = state == DATA && axi_rvld && axi_rid == id_q;
    assign good      = hit && axi_rresp == 2'b00 && !err_q && beat_q <= {1'b0, len_q};
    assign err_now   = err_q | (hit & !good) | (hit & axi_rlast & (beat_q != {1'b0, len_q}));

    assign cmd_rdy     = state == IDLE;
    assign ld_busy     = !cmd_rdy;
    assign axi_arvld   = state == AR;
    assign axi_rrdy    = state == DATA;
    assign ld_done     = state == DONE;
    assign ld_err      = state == ERR;
    assign axi_arid    = id_q;
    assign axi_araddr  = dram_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = size_q;
    assign axi_arburst = {1'b0, axi_arvld};
    assign sram_vld    = good;
    assign sram_wen    = good;
    assign sram_addr   = sram_q + SRAM_AW'(beat_q);
    assign sram_din    = good ? axi_rdata : '0;
    assign sram_type   = ld_busy ? type_q : cmd_sram_type;

    always_comb begin
        state_d = state;
        id_d    = id_q;
        dram_d  = dram_q;
        sram_d  = sram_q;
        size_d  = size_q;
        type_d  = type_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        retry_d = retry_cnt;
        case (state)
            IDLE: if (cmd_vld) begin
                id_d    = cmd_id;
                dram_d  = cmd_dram_addr;
                sram_d  = cmd_sram_addr;
                size_d  = cmd_size;
                type_d  = cmd_sram_type;
                rem_d   = cmd_len;
                len_d   = first_len(cmd_len);
                retry_d = '0;
                state_d = cmd_len == '0 ? DONE : AR;
            end
            AR: if (axi_arrdy) begin
                beat_d  = '0;
                err_d   = 1'b0;
                state_d = DATA;
            end
            DATA: if (hit) begin
                beat_d = good ? beat_q + 9'd1 : beat_q;
                err_d  = err_now;
                if (axi_rlast && err_now) begin
                    retry_d = 32'(retry_cnt) < 32'(MAX_RETRY) ? retry_cnt + RETRY_W'(1) : retry_cnt;
                    state_d = 32'(retry_cnt) < 32'(MAX_RETRY) ? AR : ERR;
                end else if (axi_rlast) begin
                    rem_d   = rem_next;
                    sram_d  = sram_q + SRAM_AW'(beats);
                    dram_d  = dram_q + DRAM_AW'(32'(beats) << size_q);
                    len_d   = first_len(rem_next);
                    retry_d = '0;
                    state_d = rem_next == '0 ? DONE : AR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            id_q      <= '0;
            dram_q    <= '0;
            sram_q    <= '0;
            size_q    <= '0;
            type_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_d;
            id_q      <= id_d;
            dram_q    <= dram_d;
            sram_q    <= sram_d;
            size_q    <= size_d;
            type_q    <= type_d;
            rem_q     <= rem_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            retry_cnt <= retry_d;
        end
    end
endmodule

// File: tb/tb_load_burst_engine.sv
// tb_load_burst_engine: directed scenarios against load_burst_engine with a hand-driven AXI slave.
module tb_load_burst_engine;
    logic        clk = 0, rst_n = 1;
    logic        cmd_vld = 0, cmd_rdy;
    logic [7:0]  cmd_id = 0, cmd_len = 0, cmd_sram_addr = 0;
    logic [11:0] cmd_dram_addr = 0;
    logic [2:0]  cmd_size = 0;
    logic [1:0]  cmd_sram_type = 0;
    logic [7:0]  axi_arid, axi_arlen, axi_rid = 0;
    logic [11:0] axi_araddr;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst, axi_rresp = 0, sram_type, retry_cnt;
    logic        axi_arvld, axi_arrdy = 0, axi_rlast = 0, axi_rvld = 0, axi_rrdy;
    logic [31:0] axi_rdata = 0, sram_din;
    logic        sram_vld, sram_wen, ld_done, ld_err, ld_busy;
    logic [7:0]  sram_addr;

    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [31:0] mem [256];
    logic [1:0]  wtype;

    load_burst_engine dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_id(cmd_id),
        .cmd_dram_addr(cmd_dram_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_sram_addr(cmd_sram_addr), .cmd_sram_type(cmd_sram_type),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvld(axi_arvld), .axi_arrdy(axi_arrdy),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvld(axi_rvld), .axi_rrdy(axi_rrdy), .sram_vld(sram_vld), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_type(sram_type), .ld_done(ld_done),
        .ld_err(ld_err), .ld_busy(ld_busy), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sram_vld === 1'b1 && sram_wen === 1'b1) begin
            mem[sram_addr] = sram_din;
            wtype = sram_type;
            wr_cnt++;
        end
        if (ld_done === 1'b1) done_cnt++;
        if (ld_err === 1'b1) err_cnt++;
    end

    task automatic start_cmd(input logic [7:0] id, input logic [11:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [7:0] sa, input logic [1:0] t);
        cmd_id = id; cmd_dram_addr = a; cmd_len = l; cmd_size = s; cmd_sram_addr = sa; cmd_sram_type = t;
        cmd_vld = 1;
        @(posedge clk); #1;
        cmd_vld = 0;
        cmd_sram_type = ~t;
    endtask

    task automatic do_ar(output logic [11:0] a, output logic [7:0] l, output logic [1:0] b, output int waited);
        waited = -1; a = 0; l = 0; b = 0;
        for (int i = 0; i < 40 && waited < 0; i++) begin
            @(negedge clk);
            if (axi_arvld === 1'b1) waited = i;
        end
        if (waited >= 0) begin
            a = axi_araddr; l = axi_arlen; b = axi_arburst;
            axi_arrdy = 1;
            @(posedge clk); #1;
            axi_arrdy = 0;
        end
    endtask

    task automatic beat(input logic [7:0] rid, input logic [31:0] d, input logic [1:0] resp, input logic last);
        axi_rid = rid; axi_rdata = d; axi_rresp = resp; axi_rlast = last; axi_rvld = 1;
        @(posedge clk); #1;
        axi_rvld = 0; axi_rlast = 0; axi_rdata = 0; axi_rresp = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if ({cmd_rdy, axi_arvld, axi_rrdy, sram_vld, sram_wen, ld_done, ld_err, ld_busy} !== 8'b1000_0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 10000000", {cmd_rdy, axi_arvld, axi_rrdy, sram_vld, sram_wen, ld_done, ld_err, ld_busy});
        end
        n_cmp++; if ({axi_araddr, axi_arlen, axi_arid, axi_arsize, axi_arburst, retry_cnt} !== 35'd0) begin
            n_bad++; $display("FAIL reset_payload: got %h want 0", {axi_araddr, axi_arlen, axi_arid, axi_arsize, axi_arburst, retry_cnt});
        end
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        n_cmp++; if (cmd_rdy !== 1'b1 || ld_busy !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: got rdy=%b busy=%b want 1 0", cmd_rdy, ld_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_len;
        start_cmd(8'h01, 12'h080, 8'd0, 3'd2, 8'h00, 2'd0);
        @(negedge clk);
        n_cmp++; if ({ld_done, axi_arvld, cmd_rdy} !== 3'b100) begin
            n_bad++; $display("FAIL zero_len_done: got done/arvld/rdy=%b want 100", {ld_done, axi_arvld, cmd_rdy});
        end
        @(negedge clk);
        n_cmp++; if ({ld_done, cmd_rdy} !== 2'b01) begin
            n_bad++; $display("FAIL zero_len_idle: got done/rdy=%b want 01", {ld_done, cmd_rdy});
        end
    endtask

    task automatic test_single;
        logic [11:0] a; logic [7:0] l; logic [1:0] b; int wt;
        int w0 = wr_cnt, d0 = done_cnt;
        start_cmd(8'h05, 12'h100, 8'd4, 3'd2, 8'h10, 2'd1);
        do_ar(a, l, b, wt);
        n_cmp++; if ({wt[7:0], a, l, b} !== {8'd0, 12'h100, 8'd3, 2'b01}) begin
            n_bad++; $display("FAIL single_ar: got wait=%0d addr=%h len=%0d burst=%b want 0 100 3 01", wt, a, l, b);
        end
        n_cmp++; if ({axi_arid, axi_arsize} !== {8'h05, 3'd2}) begin
            n_bad++; $display("FAIL single_id_size: got %h %0d want 05 2", axi_arid, axi_arsize);
        end
        for (int i = 0; i < 4; i++) beat(8'h05, 32'hA0 + i, 2'b00, i == 3);
        @(negedge clk);
        n_cmp++; if ({ld_done, cmd_rdy} !== 2'b10) begin
            n_bad++; $display("FAIL single_done: got done/rdy=%b want 10", {ld_done, cmd_rdy});
        end
        @(negedge clk);
        n_cmp++; if ({ld_done, cmd_rdy} !== 2'b01) begin
            n_bad++; $display("FAIL single_idle: got done/rdy=%b want 01", {ld_done, cmd_rdy});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[8'h10 + i] !== 32'hA0 + i) begin
                n_bad++; $display("FAIL single_data[%0d]: got %h want %h", i, mem[8'h10 + i], 32'hA0 + i);
            end
        end
        n_cmp++; if ({wr_cnt - w0, done_cnt - d0, 30'(wtype)} !== {32'd4, 32'd1, 30'd1}) begin
            n_bad++; $display("FAIL single_counts: got writes=%0d dones=%0d type=%0d want 4 1 1", wr_cnt - w0, done_cnt - d0, wtype);
        end
    endtask

    task automatic test_split;
        logic [11:0] a; logic [7:0] l; logic [1:0] b; int wt;
        int w0 = wr_cnt, d0 = done_cnt;
        start_cmd(8'h07, 12'h100, 8'd20, 3'd2, 8'h00, 2'd2);
        do_ar(a, l, b, wt);
        n_cmp++; if ({wt[7:0], a, l} !== {8'd0, 12'h100, 8'd15}) begin
            n_bad++; $display("FAIL split_ar0: got wait=%0d addr=%h len=%0d want 0 100 15", wt, a, l);
        end
        for (int i = 0; i < 16; i++) beat(8'h07, 32'h5100_0000 + i, 2'b00, i == 15);
        do_ar(a, l, b, wt);
        n_cmp++; if ({wt[7:0], a, l} !== {8'd0, 12'h140, 8'd3}) begin
            n_bad++; $display("FAIL split_ar1: got wait=%0d addr=%h len=%0d want 0 140 3", wt, a, l);
        end
        for (int i = 16; i < 20; i++) beat(8'h07, 32'h5100_0000 + i, 2'b00, i == 19);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (mem[i] !== 32'h5100_0000 + i) begin
                n_bad++; $display("FAIL split_data[%0d]: got %h want %h", i, mem[i], 32'h5100_0000 + i);
            end
        end
        n_cmp++; if ({wr_cnt - w0, done_cnt - d0} !== {32'd20, 32'd1}) begin
            n_bad++; $display("FAIL split_counts: got writes=%0d dones=%0d want 20 1", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_retry;
        logic [11:0] a; logic [7:0] l; logic [1:0] b; int wt;
        int w0 = wr_cnt, d0 = done_cnt;
        start_cmd(8'h03, 12'h200, 8'd4, 3'd2, 8'h10, 2'd0);
        do_ar(a, l, b, wt);
        for (int i = 0; i < 4; i++) beat(8'h03, 32'hB0 + i, (i == 2) ? 2'b10 : 2'b00, i == 3);
        n_cmp++; if (wr_cnt - w0 !== 2) begin
            n_bad++; $display("FAIL retry_first_writes: got %0d want 2", wr_cnt - w0);
        end
        do_ar(a, l, b, wt);
        n_cmp++; if ({wt[7:0], a, l, retry_cnt} !== {8'd0, 12'h200, 8'd3, 2'd1}) begin
            n_bad++; $display("FAIL retry_ar: got wait=%0d addr=%h len=%0d retry=%0d want 0 200 3 1", wt, a, l, retry_cnt);
        end
        for (int i = 0; i < 4; i++) beat(8'h03, 32'hC0 + i, 2'b00, i == 3);
        @(negedge clk);
        n_cmp++; if ({ld_done, retry_cnt} !== 3'b100) begin
            n_bad++; $display("FAIL retry_done: got done=%b retry=%0d want 1 0", ld_done, retry_cnt);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[8'h10 + i] !== 32'hC0 + i) begin
                n_bad++; $display("FAIL retry_data[%0d]: got %h want %h", i, mem[8'h10 + i], 32'hC0 + i);
            end
        end
        n_cmp++; if ({wr_cnt - w0, done_cnt - d0} !== {32'd6, 32'd1}) begin
            n_bad++; $display("FAIL retry_counts: got writes=%0d dones=%0d want 6 1", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_exhaust;
        logic [11:0] a; logic [7:0] l; logic [1:0] b; int wt;
        int w0 = wr_cnt, d0 = done_cnt, e0 = err_cnt;
        start_cmd(8'h0A, 12'h300, 8'd2, 3'd2, 8'h40, 2'd0);
        for (int p = 0; p < 4; p++) begin
            do_ar(a, l, b, wt);
            n_cmp++; if ({wt[7:0], a, retry_cnt} !== {8'd0, 12'h300, 2'(p)}) begin
                n_bad++; $display("FAIL exhaust_ar%0d: got wait=%0d addr=%h retry=%0d want 0 300 %0d", p, wt, a, retry_cnt, p);
            end
            for (int i = 0; i < 2; i++) beat(8'h0A, 32'hE0 + i, 2'b10, i == 1);
        end
        @(negedge clk);
        n_cmp++; if ({ld_err, ld_done, axi_arvld, retry_cnt} !== 5'b10011) begin
            n_bad++; $display("FAIL exhaust_err: got err/done/arvld/retry=%b want 10011", {ld_err, ld_done, axi_arvld, retry_cnt});
        end
        @(negedge clk);
        n_cmp++; if ({ld_err, cmd_rdy, axi_arvld} !== 3'b010) begin
            n_bad++; $display("FAIL exhaust_idle: got err/rdy/arvld=%b want 010", {ld_err, cmd_rdy, axi_arvld});
        end
        n_cmp++; if ({wr_cnt - w0, done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd0, 32'd1}) begin
            n_bad++; $display("FAIL exhaust_counts: got writes=%0d dones=%0d errs=%0d want 0 0 1", wr_cnt - w0, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_backpressure_foreign;
        int w0 = wr_cnt, d0 = done_cnt;
        start_cmd(8'h09, 12'h040, 8'd3, 3'd2, 8'h20, 2'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if ({axi_arvld, axi_araddr, axi_arlen, axi_arid} !== {1'b1, 12'h040, 8'd2, 8'h09}) begin
                n_bad++; $display("FAIL bp_hold%0d: got arvld=%b addr=%h len=%0d id=%h want 1 040 2 09", c, axi_arvld, axi_araddr, axi_arlen, axi_arid);
            end
        end
        axi_arrdy = 1;
        @(posedge clk); #1 axi_arrdy = 0;
        beat(8'h09, 32'hF0, 2'b00, 1'b0);
        beat(8'h44, 32'hBAD0, 2'b00, 1'b0);
        beat(8'h09, 32'hF1, 2'b00, 1'b0);
        beat(8'h09, 32'hF2, 2'b00, 1'b1);
        @(negedge clk);
        n_cmp++; if (ld_done !== 1'b1) begin
            n_bad++; $display("FAIL bp_done: got %b want 1", ld_done);
        end
        @(negedge clk);
        n_cmp++; if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== {32'hF0, 32'hF1, 32'hF2}) begin
            n_bad++; $display("FAIL bp_data: got %h %h %h want f0 f1 f2", mem[8'h20], mem[8'h21], mem[8'h22]);
        end
        n_cmp++; if ({wr_cnt - w0, done_cnt - d0, 30'(wtype)} !== {32'd3, 32'd1, 30'd3}) begin
            n_bad++; $display("FAIL bp_counts: got writes=%0d dones=%0d type=%0d want 3 1 3", wr_cnt - w0, done_cnt - d0, wtype);
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] a; logic [7:0] l; logic [1:0] b; int wt;
        int w0, d0;
        start_cmd(8'h01, 12'h100, 8'd4, 3'd2, 8'h30, 2'd0);
        do_ar(a, l, b, wt);
        beat(8'h01, 32'h11, 2'b00, 1'b0);
        rst_n = 1;
        @(negedge clk);
        n_cmp++; if ({cmd_rdy, axi_arvld, axi_rrdy, ld_busy, ld_done, ld_err} !== 6'b100000) begin
            n_bad++; $display("FAIL midreset_ctrl: got %b want 100000", {cmd_rdy, axi_arvld, axi_rrdy, ld_busy, ld_done, ld_err});
        end
        n_cmp++; if ({axi_araddr, axi_arlen, axi_arid, retry_cnt, sram_addr} !== 38'd0) begin
            n_bad++; $display("FAIL midreset_payload: got %h want 0", {axi_araddr, axi_arlen, axi_arid, retry_cnt, sram_addr});
        end
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        w0 = wr_cnt; d0 = done_cnt;
        start_cmd(8'h02, 12'h010, 8'd2, 3'd3, 8'h50, 2'd1);
        do_ar(a, l, b, wt);
        n_cmp++; if ({wt[7:0], a, l} !== {8'd0, 12'h010, 8'd1}) begin
            n_bad++; $display("FAIL midreset_ar: got wait=%0d addr=%h len=%0d want 0 010 1", wt, a, l);
        end
        beat(8'h02, 32'h77, 2'b00, 1'b0);
        beat(8'h02, 32'h78, 2'b00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({mem[8'h50], mem[8'h51], wr_cnt - w0, done_cnt - d0} !== {32'h77, 32'h78, 32'd2, 32'd1}) begin
            n_bad++; $display("FAIL midreset_cmd: got %h %h writes=%0d dones=%0d want 77 78 2 1", mem[8'h50], mem[8'h51], wr_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset;
        test_zero_len;
        test_single;
        test_split;
        test_retry;
        test_exhaust;
        test_backpressure_foreign;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
